// File: rtl/pattern_recorder.sv
// pattern_recorder: button/live-pitch editor that owns the playback beats bus.
// Optional define PATTERN_DEBOUNCE_EN adds a per-button debounce stage.
module pattern_recorder #(
    parameter int NUM_BEATS   = 16,
    parameter int CLK_FREQ    = 12_000_000,
    parameter int DEBOUNCE_MS = 10
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         btn_next,
    input  logic                         btn_prev,
    input  logic                         btn_up,
    input  logic                         btn_down,
    input  logic                         btn_write,
    input  logic                         rec_arm,
    input  logic [3:0]                   live_pitch,
    input  logic [$clog2(NUM_BEATS)-1:0] beat_count,
    output logic [NUM_BEATS*4-1:0]       beats,
    output logic [$clog2(NUM_BEATS)-1:0] cursor,
    output logic [3:0]                   edit_pitch,
    output logic                         recording,
    output logic                         wr_strobe
);

    localparam int CW = $clog2(NUM_BEATS);
    localparam logic [CW-1:0] LAST = CW'(NUM_BEATS - 1);

    if (NUM_BEATS < 2 || CLK_FREQ < 1000 || DEBOUNCE_MS < 1) begin : g_bad_cfg
        $error("pattern_recorder: unsupported parameters");
    end

    typedef enum logic [1:0] {
        EDIT,
        ARMED,
        RECORD,
        CLEAR
    } state_t;

    // bit order: {write, down, up, prev, next}
    logic [4:0] raw;
    logic [4:0] sync1;
    logic [4:0] sync2;
    logic [4:0] clean;
    logic [4:0] hist;
    logic [4:0] press;
    logic       arm_s1;
    logic       arm_s2;

    logic p_next;
    logic p_prev;
    logic p_up;
    logic p_down;
    logic p_write;

    assign raw = {btn_write, btn_down, btn_up, btn_prev, btn_next};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1  <= '0;
            sync2  <= '0;
            arm_s1 <= 1'b0;
            arm_s2 <= 1'b0;
        end else begin
            sync1  <= raw;
            sync2  <= sync1;
            arm_s1 <= rec_arm;
            arm_s2 <= arm_s1;
        end
    end

`ifdef PATTERN_DEBOUNCE_EN
    localparam int DB_RAW    = CLK_FREQ / 1000 * DEBOUNCE_MS;
    localparam int DB_CYCLES = (DB_RAW < 1) ? 1 : DB_RAW;
    localparam int DBW       = $clog2(DB_CYCLES + 1);

    logic [DBW-1:0] db_cnt [5];

    // clean only follows sync2 once the new level has held DB_CYCLES cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clean <= '0;
            for (int i = 0; i < 5; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 5; i++) begin
                if (sync2[i] == clean[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DBW'(DB_CYCLES - 1)) begin
                    clean[i]  <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end
`else
    assign clean = sync2;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist <= '0;
        end else begin
            hist <= clean;
        end
    end

    assign press   = clean & ~hist;
    assign p_next  = press[0];
    assign p_prev  = press[1];
    assign p_up    = press[2];
    assign p_down  = press[3];
    assign p_write = press[4];

    function automatic logic [CW-1:0] inc(input logic [CW-1:0] v);
        return (v == LAST) ? '0 : v + 1'b1;
    endfunction

    function automatic logic [CW-1:0] dec(input logic [CW-1:0] v);
        return (v == '0) ? LAST : v - 1'b1;
    endfunction

    state_t        state;
    logic [CW-1:0] bc_q;
    logic [CW-1:0] clr_idx;
    logic          rec_done;
    logic          bc_chg;

    assign bc_chg = (beat_count != bc_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= EDIT;
            beats      <= '0;
            cursor     <= '0;
            edit_pitch <= 4'h0;
            recording  <= 1'b0;
            wr_strobe  <= 1'b0;
            bc_q       <= '0;
            clr_idx    <= '0;
            rec_done   <= 1'b0;
        end else begin
            bc_q      <= beat_count;
            wr_strobe <= 1'b0;
            unique case (state)
                EDIT: begin
                    if (arm_s2) begin
                        state <= ARMED;
                    end else if (p_up && p_down) begin
                        state   <= CLEAR;
                        clr_idx <= '0;
                    end else begin
                        priority case (1'b1)
                            p_write: begin
                                beats[{cursor, 2'b00} +: 4] <= edit_pitch;
                                wr_strobe <= 1'b1;
                                cursor    <= inc(cursor);
                            end
                            (p_next && !p_prev): cursor <= inc(cursor);
                            (p_prev && !p_next): cursor <= dec(cursor);
                            default: ;
                        endcase
                        unique case (1'b1)
                            p_up:    edit_pitch <= edit_pitch + 4'd1;
                            p_down:  edit_pitch <= edit_pitch - 4'd1;
                            default: ;
                        endcase
                    end
                end
                ARMED: begin
                    if (!arm_s2) begin
                        state <= EDIT;
                    end else if (bc_chg && beat_count == '0) begin
                        // entry capture lands in slot 0
                        state     <= RECORD;
                        recording <= 1'b1;
                        beats[3:0] <= live_pitch;
                        wr_strobe <= 1'b1;
                        rec_done  <= 1'b0;
                    end
                end
                RECORD: begin
                    if (!arm_s2) begin
                        state     <= EDIT;
                        recording <= 1'b0;
                    end else if (bc_chg) begin
                        if (rec_done) begin
                            state     <= EDIT;
                            recording <= 1'b0;
                        end else begin
                            beats[{beat_count, 2'b00} +: 4] <= live_pitch;
                            wr_strobe <= 1'b1;
                            rec_done  <= (beat_count == LAST);
                        end
                    end
                end
                CLEAR: begin
                    beats[{clr_idx, 2'b00} +: 4] <= 4'h0;
                    wr_strobe <= 1'b1;
                    clr_idx   <= inc(clr_idx);
                    if (clr_idx == LAST) begin
                        state <= EDIT;
                    end
                end
                default: state <= EDIT;
            endcase
        end
    end

endmodule

// File: tb/tb_pattern_recorder.sv
// tb_pattern_recorder: random and directed edits/records checked by a
// slot-array model; a monitor compares beats on every wr_strobe.
`timescale 1ns/1ps
module tb_pattern_recorder;

    localparam int N  = 16;
    localparam int CW = 4;
`ifdef PATTERN_DEBOUNCE_EN
    localparam int HOLD = 24;
`else
    localparam int HOLD = 3;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            btn_next = 1'b0;
    logic            btn_prev = 1'b0;
    logic            btn_up = 1'b0;
    logic            btn_down = 1'b0;
    logic            btn_write = 1'b0;
    logic            rec_arm = 1'b0;
    logic [3:0]      live_pitch = 4'h0;
    logic [CW-1:0]   beat_count = '0;
    logic [N*4-1:0]  beats;
    logic [CW-1:0]   cursor;
    logic [3:0]      edit_pitch;
    logic            recording;
    logic            wr_strobe;

    pattern_recorder #(
        .NUM_BEATS  (N),
        .CLK_FREQ   (12_000),
        .DEBOUNCE_MS(1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_next  (btn_next),
        .btn_prev  (btn_prev),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .btn_write (btn_write),
        .rec_arm   (rec_arm),
        .live_pitch(live_pitch),
        .beat_count(beat_count),
        .beats     (beats),
        .cursor    (cursor),
        .edit_pitch(edit_pitch),
        .recording (recording),
        .wr_strobe (wr_strobe)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc++;

    typedef struct {
        logic [N*4-1:0] img;
        bit             chained;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] m_slot [N];
    int         m_cur;
    int         m_pitch;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic logic [N*4-1:0] image();
        logic [N*4-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) r[i*4 +: 4] = m_slot[i];
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_slot[i] = 4'h0;
        m_cur   = 0;
        m_pitch = 0;
    endtask

    task automatic expect_write(input int slot, input logic [3:0] val,
                                input bit chained);
        exp_t e;
        m_slot[slot] = val;
        e.img        = image();
        e.chained    = chained;
        sb.push_back(e);
    endtask

    initial begin : monitor
        int   last;
        exp_t e;
        last = -10;
        forever begin
            @(negedge clk);
            if (rst_n && wr_strobe) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_strobe: got strobe at cycle %0d, expected none", cyc);
                end else begin
                    e = sb.pop_front();
                    check("beats_on_strobe", beats, e.img);
                    if (e.chained) check("strobe_consecutive", cyc - last, 1);
                end
                last = cyc;
            end
        end
    end

    task automatic press(input bit nx, input bit pv, input bit up,
                         input bit dn, input bit wr);
        @(negedge clk);
        btn_next  = nx;
        btn_prev  = pv;
        btn_up    = up;
        btn_down  = dn;
        btn_write = wr;
        repeat (HOLD) @(negedge clk);
        btn_next  = 1'b0;
        btn_prev  = 1'b0;
        btn_up    = 1'b0;
        btn_down  = 1'b0;
        btn_write = 1'b0;
        repeat (HOLD + 3) @(negedge clk);
    endtask

    task automatic edit_op(input bit nx, input bit pv, input bit up,
                           input bit dn, input bit wr);
        if (up && dn) begin
            for (int k = 0; k < N; k++) expect_write(k, 4'h0, k != 0);
        end else begin
            if (wr) begin
                expect_write(m_cur, 4'(m_pitch), 1'b0);
                m_cur = (m_cur + 1) % N;
            end else if (nx && !pv) begin
                m_cur = (m_cur + 1) % N;
            end else if (pv && !nx) begin
                m_cur = (m_cur + N - 1) % N;
            end
            if (up) m_pitch = (m_pitch + 1) % 16;
            else if (dn) m_pitch = (m_pitch + 15) % 16;
        end
        press(nx, pv, up, dn, wr);
        if (up && dn) repeat (N + 4) @(negedge clk);
        check("cursor", cursor, m_cur);
        check("edit_pitch", edit_pitch, m_pitch);
    endtask

    task automatic step_beat(input int b, input logic [3:0] lp,
                             input bit cap, input int hold);
        @(negedge clk);
        beat_count = CW'(b);
        live_pitch = lp;
        if (cap) expect_write(b, lp, 1'b0);
        repeat (hold - 1) begin
            @(negedge clk);
            live_pitch = 4'($urandom);
        end
    endtask

    task automatic arm_wait();
        @(negedge clk);
        beat_count = CW'(N - 1);
        repeat (2) @(negedge clk);
        rec_arm = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    initial begin : watchdog
        #500_000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1);
    end

    initial begin : stim
        int op;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_beats", beats, '0);
        check("rst_cursor", cursor, 0);
        check("rst_pitch", edit_pitch, 0);
        check("rst_recording", recording, 0);
        check("rst_strobe", wr_strobe, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // up x3, write, then wrap cursor and pitch both ways
        repeat (3) edit_op(0, 0, 1, 0, 0);
        edit_op(0, 0, 0, 0, 1);
        check("slot0_is_3", beats[3:0], 4'h3);
        edit_op(0, 1, 0, 0, 0);
        edit_op(0, 1, 0, 0, 0);
        edit_op(1, 0, 0, 0, 0);
        repeat (4) edit_op(0, 0, 0, 1, 0);
        edit_op(0, 0, 1, 0, 0);

        // slots 0..3 = 5, then clear the whole pattern
        while (m_pitch != 5) edit_op(0, 0, 1, 0, 0);
        repeat (4) edit_op(0, 0, 0, 0, 1);
        edit_op(0, 0, 1, 1, 0);
        check("clear_all_zero", beats, '0);

        // random edit traffic
        for (int i = 0; i < 30; i++) begin
            op = $urandom_range(0, 10);
            case (op)
                0: edit_op(1, 0, 0, 0, 0);
                1: edit_op(0, 1, 0, 0, 0);
                2: edit_op(0, 0, 1, 0, 0);
                3: edit_op(0, 0, 0, 1, 0);
                4: edit_op(0, 0, 0, 0, 1);
                5: edit_op(1, 1, 0, 0, 0);
                6: edit_op(1, 0, 0, 0, 1);
                7: edit_op(0, 1, 0, 0, 1);
                8: edit_op(0, 0, 1, 0, 1);
                9: edit_op(0, 0, 0, 1, 1);
                default: edit_op(0, 0, 1, 1, 0);
            endcase
        end

        // full record pass: slot i gets i+1 (4-bit)
        arm_wait();
        check("armed_not_recording", recording, 0);
        for (int s = 0; s < N; s++) begin
            step_beat(s, 4'(s + 1), 1'b1, 4);
            if (s == 0) check("recording_high", recording, 1);
        end
        @(negedge clk);
        beat_count = '0;
        rec_arm    = 1'b0;
        @(negedge clk);
        check("recording_drop", recording, 0);
        repeat (6) @(negedge clk);
        check("record_image", beats, image());
        check("slot15_wrapped", beats[N*4-1 -: 4], 4'h0);
        edit_op(1, 0, 0, 0, 0);

        // abort after slot 5
        arm_wait();
        for (int s = 0; s < 6; s++) step_beat(s, 4'($urandom), 1'b1, (s == 5) ? 2 : 4);
        rec_arm = 1'b0;
        repeat (8) @(negedge clk);
        check("abort_recording", recording, 0);
        for (int s = 6; s < 10; s++) step_beat(s, 4'($urandom), 1'b0, 3);
        check("abort_image", beats, image());
        edit_op(0, 0, 1, 0, 0);

        // reset in the middle of a record pass
        arm_wait();
        for (int s = 0; s < 3; s++) step_beat(s, 4'($urandom), 1'b1, 4);
        check("pre_reset_recording", recording, 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_beats", beats, '0);
        check("midrst_cursor", cursor, 0);
        check("midrst_pitch", edit_pitch, 0);
        check("midrst_recording", recording, 0);
        check("midrst_strobe", wr_strobe, 0);
        check("midrst_sb_drained", sb.size(), 0);
        sb.delete();
        model_reset();
        rec_arm = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        edit_op(0, 0, 1, 0, 0);
        edit_op(0, 0, 0, 0, 1);

`ifdef PATTERN_DEBOUNCE_EN
        @(negedge clk);
        btn_next = 1'b1;
        repeat (5) @(negedge clk);
        btn_next = 1'b0;
        repeat (30) @(negedge clk);
        check("glitch_no_move", cursor, m_cur);
        btn_next = 1'b1;
        repeat (20) @(negedge clk);
        btn_next = 1'b0;
        repeat (30) @(negedge clk);
        m_cur = (m_cur + 1) % N;
        check("held_moves_once", cursor, m_cur);
`endif

        repeat (4) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
